// File: rtl/msg_pkg.sv
// Shared definitions for the message path: transmitter FSM states, ASCII
// constants used by the message stage, baud divisor and parity helper.
package msg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic [7:0] HASH    = 8'h23;
    localparam logic [7:0] DASH    = 8'h2D;
    localparam logic [7:0] CH_D    = 8'h44;
    localparam logic [7:0] CH_E    = 8'h45;
    localparam logic [7:0] CH_F    = 8'h46;
    localparam logic [7:0] CH_N    = 8'h4E;
    localparam logic [7:0] CH_P    = 8'h50;
    localparam logic [7:0] CH_R    = 8'h52;
    localparam logic [7:0] DIGIT_0 = 8'h30;

    localparam int unsigned CLKS_50M_115200 = 32'd434;

    // Even parity bit: XOR of all data bits.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_msg_tx_if.sv
// Byte-stream handshake and UART status signals between the message stage
// (master) and the transmitter (slave).
interface uart_msg_tx_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       tx;
    logic       busy;
    logic       msg_done;
    logic       overflow;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, tx, busy, msg_done, overflow
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, tx, busy, msg_done, overflow
    );
endinterface

// File: rtl/msg_byte_fifo.sv
// Synchronous byte FIFO; full/empty are registered from the next-state count
// so a write is refused whenever the FIFO was full before the edge.
module msg_byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push_s, do_pop_s;

    // Pointer and occupancy next-state.
    always_comb begin
        do_push_s = push && !full_q;
        do_pop_s  = pop && !empty_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_CNT);
            empty_q  <= (count_d == {(AW+1){1'b0}});
        end
    end

    // Storage; contents are meaningless after reset because the pointers restart.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/uart_msg_tx.sv
// Buffered UART transmitter for the event message stream, 8N1 by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_msg_tx
    import msg_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_50M_115200,
    parameter int unsigned FIFO_DEPTH   = 32'd16,
    parameter logic [7:0]  TERM_BYTE    = HASH
) (
    input  logic         clk_50M,
    input  logic         rst,
    uart_msg_tx_if.slave bus
);
    localparam int unsigned    BW        = $clog2(CLKS_PER_BIT);
    localparam int unsigned    CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic          done_stage_q, msg_done_q;
    logic          term_done_s, baud_last_s;
    logic          push_s, pop_s;
    logic [7:0]    fifo_dout_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [CW-1:0] fifo_count_s;

    assign push_s      = bus.byte_valid && !fifo_full_s;
    assign baud_last_s = (baud_q == BAUD_LAST);

    msg_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32'd8)
    ) u_fifo (
        .clk   (clk_50M),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (bus.byte_in),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Frame sequencer: STOP chains straight into the next START when data waits.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        tx_byte_d   = tx_byte_q;
        pop_s       = 1'b0;
        term_done_s = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = {BW{1'b0}};
                bit_d  = 3'd0;
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    tx_byte_d = fifo_dout_s;
                    state_d   = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_last_s) begin
                    baud_d  = {BW{1'b0}};
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_last_s) begin
                    baud_d = {BW{1'b0}};
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last_s) begin
                    baud_d  = {BW{1'b0}};
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`endif
            STOP: begin
                if (baud_last_s) begin
                    baud_d      = {BW{1'b0}};
                    term_done_s = (tx_byte_q == TERM_BYTE);
                    if (!fifo_empty_s) begin
                        pop_s     = 1'b1;
                        tx_byte_d = fifo_dout_s;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = {BW{1'b0}};
                bit_d   = 3'd0;
            end
        endcase
    end

    // Line level follows the state one cycle later, so tx/busy/msg_done share a timebase.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = tx_byte_q[bit_q];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = even_parity(tx_byte_q);
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d     = (state_q != IDLE) || (fifo_count_s != {CW{1'b0}});
        overflow_d = overflow_q || (bus.byte_valid && fifo_full_s);
    end

    // State and output registers.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            baud_q       <= {BW{1'b0}};
            bit_q        <= 3'd0;
            tx_byte_q    <= 8'h00;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            done_stage_q <= 1'b0;
            msg_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            tx_byte_q    <= tx_byte_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            done_stage_q <= term_done_s;
            msg_done_q   <= done_stage_q;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.msg_done   = msg_done_q;
    assign bus.overflow   = overflow_q;
    assign bus.byte_ready = !fifo_full_s;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Self-checking bench for uart_msg_tx: frame-timeline model plus directed cases.
module tb_uart_msg_tx;
    localparam int CPB   = 16;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int   NB        = 11;
    localparam logic SLOT9_03  = 1'b0;
`else
    localparam int   NB        = 10;
    localparam logic SLOT9_03  = 1'b1;
`endif
    localparam int FRAME = NB * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_msg_tx_if bus();

    uart_msg_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .TERM_BYTE    (8'h23)
    ) dut (
        .clk_50M (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        int         acc;
        int         t;
    } frame_t;

    frame_t     frames[$];
    int         last_end = 0;
    logic       ovf_exp  = 1'b0;
    bit         model_on = 1'b0;
    int         checks   = 0;
    int         errors   = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    logic [7:0] stim[17];
    int         exp45[8] = '{1, 0, 1, 0, 0, 0, 1, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cyc %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Line level at cycle n: start 0, data LSB first, optional parity, then stop/idle 1.
    function automatic logic exp_tx(input int n);
        foreach (frames[i]) begin
            if (n >= frames[i].t && n < frames[i].t + FRAME) begin
                int k;
                k = (n - frames[i].t) / CPB;
                if (k == 0) return 1'b0;
                if (k <= 8) return frames[i].b[k-1];
`ifdef UART_TX_PARITY_EN
                if (k == 9) return ^frames[i].b;
`endif
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int n);
        foreach (frames[i])
            if (frames[i].acc < n && n < frames[i].t + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_done(input int n);
        foreach (frames[i])
            if (frames[i].b == 8'h23 && frames[i].t + FRAME == n) return 1'b1;
        return 1'b0;
    endfunction

    // Bytes accepted but not yet taken for transmission after edge m.
    function automatic int held_after(input int m);
        int c = 0;
        foreach (frames[i])
            if (frames[i].acc <= m && frames[i].t - 1 > m) c++;
        return c;
    endfunction

    // Compare process: check outputs for the edge just passed, then book the pending strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                frames.delete();
                last_end = 0;
                ovf_exp  = 1'b0;
            end else if (model_on) begin
                chk("tx",         32'(bus.tx),         32'(exp_tx(cyc)));
                chk("busy",       32'(bus.busy),       32'(exp_busy(cyc)));
                chk("msg_done",   32'(bus.msg_done),   32'(exp_done(cyc)));
                chk("byte_ready", 32'(bus.byte_ready), 32'(held_after(cyc) < DEPTH));
                chk("overflow",   32'(bus.overflow),   32'(ovf_exp));
                if (bus.msg_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (bus.byte_valid) begin
                    frame_t f;
                    if (held_after(cyc) < DEPTH) begin
                        f.b   = bus.byte_in;
                        f.acc = cyc + 1;
                        f.t   = (cyc + 3 > last_end) ? cyc + 3 : last_end;
                        last_end = f.t + FRAME;
                        frames.push_back(f);
                    end else begin
                        ovf_exp = 1'b1;
                    end
                end
            end
        end
    end

    task automatic goto(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic send(input int nbytes, output int first_acc);
        first_acc = 0;
        for (int i = 0; i < nbytes; i++) begin
            @(posedge clk);
            #1;
            bus.byte_in    = stim[i];
            bus.byte_valid = 1'b1;
            if (i == 0) first_acc = cyc + 1;
        end
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        repeat (3) @(negedge clk);
        while (bus.busy && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 32'(k < 20000), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, t0, p;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        model_on = 1'b1;
        @(negedge clk);
        chk("rst_tx",       32'(bus.tx),         32'd1);
        chk("rst_ready",    32'(bus.byte_ready), 32'd1);
        chk("rst_busy",     32'(bus.busy),       32'd0);
        chk("rst_msg_done", 32'(bus.msg_done),   32'd0);
        chk("rst_overflow", 32'(bus.overflow),   32'd0);

        // Single 0x45 frame.
        stim[0] = 8'h45;
        send(1, a);
        goto(a + 1);
        chk("lat_edge1_tx", 32'(bus.tx), 32'd1);
        goto(a + 2);
        chk("lat_edge2_tx", 32'(bus.tx), 32'd0);
        for (int k = 0; k < 8; k++) begin
            goto(a + 2 + CPB * (k + 1) + CPB / 2);
            chk("bit45", 32'(bus.tx), 32'(exp45[k]));
        end
        goto(a + 1 + FRAME);
        chk("busy_end_hi", 32'(bus.busy), 32'd1);
        goto(a + 2 + FRAME);
        chk("busy_end_lo", 32'(bus.busy), 32'd0);
        chk("no_done_45", 32'(done_cnt), 32'd0);

        // "END-#" back to back.
        stim[0] = 8'h45; stim[1] = 8'h4E; stim[2] = 8'h44; stim[3] = 8'h2D; stim[4] = 8'h23;
        done_cnt = 0;
        send(5, a);
        t0 = a + 2;
        goto(t0 + FRAME);
        chk("b2b_start", 32'(bus.tx), 32'd0);
        goto(t0 + 5 * FRAME + 3);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("done_cycle", 32'(done_cyc), 32'(t0 + 5 * FRAME));
        chk("msg_ovf",    32'(bus.overflow), 32'd0);

        // Overflow: 17 strobes while a frame holds the line.
        stim[0] = 8'h31;
        send(1, a);
        goto(a + 5);
        for (int i = 0; i < 17; i++) stim[i] = 8'h41 + 8'(i);
        send(17, b);
        chk("full_ready", 32'(bus.byte_ready), 32'd0);
        chk("ovf_set",    32'(bus.overflow),   32'd1);
        goto(b + 40);
        chk("ovf_hold", 32'(bus.overflow), 32'd1);
        wait_idle();
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        do_reset();
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Reset during data bit 2 of 0x23.
        done_cnt = 0;
        stim[0] = 8'h23;
        send(1, a);
        t0 = a + 2;
        goto(t0 + 3 * CPB + CPB / 2);
        chk("pre_rst_tx", 32'(bus.tx), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_tx",    32'(bus.tx),               32'd1);
        chk("async_busy",  32'(bus.busy),             32'd0);
        chk("async_ready", 32'(bus.byte_ready),       32'd1);
        chk("async_done",  32'(bus.msg_done),         32'd0);
        chk("async_count", 32'(dut.u_fifo.count_q),   32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (FRAME + 20) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        stim[0] = 8'h41;
        send(1, a);
        wait_idle();

        // Ninth bit slot: parity when enabled, stop bit otherwise.
        stim[0] = 8'h07;
        send(1, a);
        goto(a + 2 + 9 * CPB + CPB / 2);
        chk("slot9_07", 32'(bus.tx), 32'd1);
        goto(a + 1 + FRAME);
        chk("len07_hi", 32'(bus.busy), 32'd1);
        goto(a + 2 + FRAME);
        chk("len07_lo", 32'(bus.busy), 32'd0);
        stim[0] = 8'h03;
        send(1, a);
        goto(a + 2 + 9 * CPB + CPB / 2);
        chk("slot9_03", 32'(bus.tx), 32'(SLOT9_03));
        wait_idle();

        // Push and pop on the same edge with three bytes held (includes a 0x00 byte).
        stim[0] = 8'h10; stim[1] = 8'h00; stim[2] = 8'h20; stim[3] = 8'h30;
        send(4, a);
        chk("cnt3_before", 32'(dut.u_fifo.count_q), 32'd3);
        p = a + 1 + FRAME;
        goto(p - 2);
        stim[0] = 8'h40;
        send(1, b);
        chk("pushpop_edge", 32'(b), 32'(p));
        chk("cnt3_after", 32'(dut.u_fifo.count_q), 32'd3);
        wait_idle();
        chk("final_ovf", 32'(bus.overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
